// File: rtl/ex_alu_forward.sv
// ex_alu_forward: execute-stage datapath slice of the pipelined MIPS-style CPU.
//
// Resolves MEM/WB operand forwarding for rs and rt, selects the B operand,
// computes the ALU result, the address sum and the zero flag, and registers
// the result and the forwarded store data into the EX/MEM boundary.
//
// Ports:
//   clk, rst             pipeline clock; synchronous active-low reset
//   flush                squashes the registered valid bit (data held)
//   in_valid             current EX instruction is live
//   rs, rt               source register indices
//   rd1, rd2             register-file read data from ID/EX
//   ext_b                extended immediate
//   alu_src              1: B = ext_b, 0: B = forwarded rt value
//   aluop, sa            ALU function code, shift amount
//   use_mem_back         enable forwarding from the MEM stage
//   use_wb_back          enable forwarding from the WB stage
//   mem_we/rw/data       MEM-stage writeback (enable, destination, value)
//   wb_we/rw/data        WB-stage writeback (enable, destination, value)
//   f_rd1, f_rd2         forwarded operands (combinational)
//   alu_c, sum, zero     ALU result, A+B, alu_c == 0 (combinational)
//   c_q, st_q, valid_q   registered alu_c, f_rd2 and valid

module ex_alu_forward (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  input  logic [31:0] ext_b,
  input  logic        alu_src,
  input  logic [3:0]  aluop,
  input  logic [4:0]  sa,
  input  logic        use_mem_back,
  input  logic        use_wb_back,
  input  logic        mem_we,
  input  logic [4:0]  mem_rw,
  input  logic [31:0] mem_data,
  input  logic        wb_we,
  input  logic [4:0]  wb_rw,
  input  logic [31:0] wb_data,
  output logic [31:0] f_rd1,
  output logic [31:0] f_rd2,
  output logic [31:0] alu_c,
  output logic [31:0] sum,
  output logic        zero,
  output logic [31:0] c_q,
  output logic [31:0] st_q,
  output logic        valid_q
);

  // ALU function codes.
  localparam logic [3:0] OpAdd   = 4'd0;
  localparam logic [3:0] OpSub   = 4'd1;
  localparam logic [3:0] OpAnd   = 4'd2;
  localparam logic [3:0] OpOr    = 4'd3;
  localparam logic [3:0] OpXor   = 4'd4;
  localparam logic [3:0] OpNor   = 4'd5;
  localparam logic [3:0] OpSlt   = 4'd6;
  localparam logic [3:0] OpSltu  = 4'd7;
  localparam logic [3:0] OpSll   = 4'd8;
  localparam logic [3:0] OpSrl   = 4'd9;
  localparam logic [3:0] OpSra   = 4'd10;
  localparam logic [3:0] OpSllv  = 4'd11;
  localparam logic [3:0] OpSrlv  = 4'd12;
  localparam logic [3:0] OpSrav  = 4'd13;
  localparam logic [3:0] OpLui   = 4'd14;
  localparam logic [3:0] OpPassb = 4'd15;

  // ---------------------------------------------------------------------------
  // Forwarding. Register 0 is hardwired, so a write to it is never forwarded.
  // ---------------------------------------------------------------------------
  logic rs_nz, rt_nz;
  logic mem_hit_a, wb_hit_a;
  logic mem_hit_b, wb_hit_b;

  assign rs_nz = (rs != 5'd0);
  assign rt_nz = (rt != 5'd0);

  assign mem_hit_a = use_mem_back && mem_we && (mem_rw == rs) && rs_nz;
  assign wb_hit_a  = use_wb_back  && wb_we  && (wb_rw  == rs) && rs_nz;
  assign mem_hit_b = use_mem_back && mem_we && (mem_rw == rt) && rt_nz;
  assign wb_hit_b  = use_wb_back  && wb_we  && (wb_rw  == rt) && rt_nz;

  // MEM holds the younger result, so it wins over WB.
  always_comb begin
    f_rd1 = rd1;
    if (mem_hit_a) begin
      f_rd1 = mem_data;
    end else if (wb_hit_a) begin
      f_rd1 = wb_data;
    end
  end

  always_comb begin
    f_rd2 = rd2;
    if (mem_hit_b) begin
      f_rd2 = mem_data;
    end else if (wb_hit_b) begin
      f_rd2 = wb_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Operands and ALU
  // ---------------------------------------------------------------------------
  logic [31:0] op_a, op_b;
  logic [4:0]  var_sh;
  logic        slt_res, sltu_res;

  assign op_a   = f_rd1;
  assign op_b   = alu_src ? ext_b : f_rd2;
  assign var_sh = op_a[4:0];

  // Address sum is always available regardless of aluop.
  assign sum = op_a + op_b;

  assign slt_res  = ($signed(op_a) < $signed(op_b));
  assign sltu_res = (op_a < op_b);

  always_comb begin
    alu_c = op_b;
    unique case (aluop)
      OpAdd:   alu_c = sum;
      OpSub:   alu_c = op_a - op_b;
      OpAnd:   alu_c = op_a & op_b;
      OpOr:    alu_c = op_a | op_b;
      OpXor:   alu_c = op_a ^ op_b;
      OpNor:   alu_c = ~(op_a | op_b);
      OpSlt:   alu_c = {31'd0, slt_res};
      OpSltu:  alu_c = {31'd0, sltu_res};
      OpSll:   alu_c = op_b << sa;
      OpSrl:   alu_c = op_b >> sa;
      OpSra:   alu_c = $unsigned($signed(op_b) >>> sa);
      OpSllv:  alu_c = op_b << var_sh;
      OpSrlv:  alu_c = op_b >> var_sh;
      OpSrav:  alu_c = $unsigned($signed(op_b) >>> var_sh);
      OpLui:   alu_c = {op_b[15:0], 16'h0000};
      OpPassb: alu_c = op_b;
      default: alu_c = op_b;
    endcase
  end

  assign zero = (alu_c == 32'd0);

  // ---------------------------------------------------------------------------
  // EX/MEM boundary registers. Flush only kills valid; data is held so a
  // squashed slot does not toggle the downstream datapath.
  // ---------------------------------------------------------------------------
  logic [31:0] c_d, st_d;
  logic        valid_d;

  always_comb begin
    c_d     = c_q;
    st_d    = st_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else begin
      c_d     = alu_c;
      st_d    = f_rd2;
      valid_d = in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      c_q     <= 32'd0;
      st_q    <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      c_q     <= c_d;
      st_q    <= st_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_ex_alu_forward.sv
module tb_ex_alu_forward;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [4:0]  rs, rt;
  logic [31:0] rd1, rd2, ext_b;
  logic        alu_src;
  logic [3:0]  aluop;
  logic [4:0]  sa;
  logic        use_mem_back, use_wb_back;
  logic        mem_we, wb_we;
  logic [4:0]  mem_rw, wb_rw;
  logic [31:0] mem_data, wb_data;
  logic [31:0] f_rd1, f_rd2, alu_c, sum;
  logic        zero;
  logic [31:0] c_q, st_q;
  logic        valid_q;

  int checks;
  int errors;

  typedef struct {
    logic [31:0] c;
    logic [31:0] st;
    logic        v;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;

  ex_alu_forward dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .rs           (rs),
    .rt           (rt),
    .rd1          (rd1),
    .rd2          (rd2),
    .ext_b        (ext_b),
    .alu_src      (alu_src),
    .aluop        (aluop),
    .sa           (sa),
    .use_mem_back (use_mem_back),
    .use_wb_back  (use_wb_back),
    .mem_we       (mem_we),
    .mem_rw       (mem_rw),
    .mem_data     (mem_data),
    .wb_we        (wb_we),
    .wb_rw        (wb_rw),
    .wb_data      (wb_data),
    .f_rd1        (f_rd1),
    .f_rd2        (f_rd2),
    .alu_c        (alu_c),
    .sum          (sum),
    .zero         (zero),
    .c_q          (c_q),
    .st_q         (st_q),
    .valid_q      (valid_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  function automatic logic [31:0] m_fwd(input logic [4:0] r, input logic [31:0] rf);
    if (r == 5'd0) return rf;
    if (use_mem_back && mem_we && mem_rw == r) return mem_data;
    if (use_wb_back && wb_we && wb_rw == r) return wb_data;
    return rf;
  endfunction

  function automatic logic [31:0] m_sra(input logic [31:0] b, input logic [4:0] s);
    logic [31:0] fill;
    fill = b[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0;
    return (b >> s) | fill;
  endfunction

  function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] s);
    logic lt;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a + ~b + 32'd1;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~a & ~b;
      4'd6: begin
        lt = (a[31] != b[31]) ? a[31] : (a < b);
        return {31'd0, lt};
      end
      4'd7:  return {31'd0, (a < b)};
      4'd8:  return b << s;
      4'd9:  return b >> s;
      4'd10: return m_sra(b, s);
      4'd11: return b << a[4:0];
      4'd12: return b >> a[4:0];
      4'd13: return m_sra(b, a[4:0]);
      4'd14: return {b[15:0], 16'h0};
      default: return b;
    endcase
  endfunction

  task automatic set_defaults();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    rs = 5'd0; rt = 5'd0; rd1 = 32'd0; rd2 = 32'd0; ext_b = 32'd0;
    alu_src = 1'b0; aluop = 4'd0; sa = 5'd0;
    use_mem_back = 1'b0; use_wb_back = 1'b0;
    mem_we = 1'b0; mem_rw = 5'd0; mem_data = 32'd0;
    wb_we = 1'b0; wb_rw = 5'd0; wb_data = 32'd0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    set_defaults();
    rst = 1'b0;
    flush = 1'b1;
    sb_q.push_back('{c: 32'd0, st: 32'd0, v: 1'b0});
    @(posedge clk); #1;
    e = sb_q.pop_front();
    checks++;
    if (c_q !== e.c || st_q !== e.st || valid_q !== e.v) begin
      errors++;
      $display("FAIL reset: c_q=%h st_q=%h valid_q=%b required %h %h %b",
               c_q, st_q, valid_q, e.c, e.st, e.v);
    end
  endtask

  task automatic test_forward();
    @(negedge clk);
    set_defaults();
    rs = 5'd5; rd1 = 32'd1;
    use_mem_back = 1'b1; use_wb_back = 1'b1;
    mem_we = 1'b1; mem_rw = 5'd5; mem_data = 32'hAA;
    wb_we = 1'b1; wb_rw = 5'd5; wb_data = 32'hBB;
    #1;
    checks++;
    if (f_rd1 !== 32'hAA) begin
      errors++; $display("FAIL fwd_mem_prio: f_rd1=%h required %h", f_rd1, 32'hAA);
    end
    mem_we = 1'b0; #1;
    checks++;
    if (f_rd1 !== 32'hBB) begin
      errors++; $display("FAIL fwd_wb: f_rd1=%h required %h", f_rd1, 32'hBB);
    end
    use_wb_back = 1'b0; #1;
    checks++;
    if (f_rd1 !== 32'h1) begin
      errors++; $display("FAIL fwd_none: f_rd1=%h required %h", f_rd1, 32'h1);
    end
    // rt path, MEM disabled by use_mem_back while WB enabled
    mem_we = 1'b1; use_mem_back = 1'b0; use_wb_back = 1'b1;
    rt = 5'd5; rd2 = 32'h77; #1;
    checks++;
    if (f_rd2 !== 32'hBB) begin
      errors++; $display("FAIL fwd_rt_wb: f_rd2=%h required %h", f_rd2, 32'hBB);
    end
  endtask

  task automatic test_r0();
    @(negedge clk);
    set_defaults();
    rt = 5'd0; rd2 = 32'd0;
    use_mem_back = 1'b1; use_wb_back = 1'b1;
    mem_we = 1'b1; mem_rw = 5'd0; mem_data = 32'hFFFF_FFFF;
    wb_we = 1'b1; wb_rw = 5'd0; wb_data = 32'h1234_5678;
    #1;
    checks++;
    if (f_rd2 !== 32'd0) begin
      errors++; $display("FAIL r0_guard_rt: f_rd2=%h required %h", f_rd2, 32'd0);
    end
    rd1 = 32'h5; #1;
    checks++;
    if (f_rd1 !== 32'h5) begin
      errors++; $display("FAIL r0_guard_rs: f_rd1=%h required %h", f_rd1, 32'h5);
    end
  endtask

  task automatic test_arith();
    @(negedge clk);
    set_defaults();
    alu_src = 1'b1;
    rd1 = 32'h7FFF_FFFF; ext_b = 32'd1; aluop = 4'd0; #1;
    checks++;
    if (alu_c !== 32'h8000_0000 || sum !== 32'h8000_0000) begin
      errors++; $display("FAIL add_wrap: alu_c=%h sum=%h required 80000000", alu_c, sum);
    end
    rd1 = 32'd3; ext_b = 32'd3; aluop = 4'd1; #1;
    checks++;
    if (alu_c !== 32'd0 || zero !== 1'b1 || sum !== 32'd6) begin
      errors++; $display("FAIL sub_zero: alu_c=%h zero=%b sum=%h required 0 1 6",
                         alu_c, zero, sum);
    end
    rd1 = 32'hFFFF_FFFF; ext_b = 32'd1; aluop = 4'd6; #1;
    checks++;
    if (alu_c !== 32'd1 || zero !== 1'b0) begin
      errors++; $display("FAIL slt: alu_c=%h zero=%b required 1 0", alu_c, zero);
    end
    aluop = 4'd7; #1;
    checks++;
    if (alu_c !== 32'd0 || zero !== 1'b1) begin
      errors++; $display("FAIL sltu: alu_c=%h zero=%b required 0 1", alu_c, zero);
    end
    rd1 = 32'hF0F0_1234; ext_b = 32'h0FF0_00FF; aluop = 4'd5; #1;
    checks++;
    if (alu_c !== 32'h000F_ED00) begin
      errors++; $display("FAIL nor: alu_c=%h required %h", alu_c, 32'h000F_ED00);
    end
  endtask

  task automatic test_shift();
    @(negedge clk);
    set_defaults();
    alu_src = 1'b1;
    ext_b = 32'h8000_0000; sa = 5'd4; aluop = 4'd9; #1;
    checks++;
    if (alu_c !== 32'h0800_0000) begin
      errors++; $display("FAIL srl: alu_c=%h required %h", alu_c, 32'h0800_0000);
    end
    aluop = 4'd10; #1;
    checks++;
    if (alu_c !== 32'hF800_0000) begin
      errors++; $display("FAIL sra: alu_c=%h required %h", alu_c, 32'hF800_0000);
    end
    rd1 = 32'd33; ext_b = 32'h4000_0003; aluop = 4'd11; #1;
    checks++;
    if (alu_c !== 32'h8000_0006) begin
      errors++; $display("FAIL sllv: alu_c=%h required %h", alu_c, 32'h8000_0006);
    end
    rd1 = 32'd0; ext_b = 32'h0000_1234; aluop = 4'd14; #1;
    checks++;
    if (alu_c !== 32'h1234_0000) begin
      errors++; $display("FAIL lui: alu_c=%h required %h", alu_c, 32'h1234_0000);
    end
    // sum stays A+B for a non-add op
    rd1 = 32'h10; ext_b = 32'h20; aluop = 4'd15; #1;
    checks++;
    if (alu_c !== 32'h20 || sum !== 32'h30) begin
      errors++; $display("FAIL passb_sum: alu_c=%h sum=%h required 20 30", alu_c, sum);
    end
  endtask

  task automatic test_register_flush();
    @(negedge clk);
    set_defaults();
    rd1 = 32'd2; rd2 = 32'd3; rt = 5'd3; alu_src = 1'b0; aluop = 4'd0; in_valid = 1'b1;
    sb_q.push_back('{c: 32'd5, st: 32'd3, v: 1'b1});
    @(posedge clk); #1;
    e = sb_q.pop_front();
    checks++;
    if (c_q !== e.c || st_q !== e.st || valid_q !== e.v) begin
      errors++; $display("FAIL reg_add: c_q=%h st_q=%h valid_q=%b required %h %h %b",
                         c_q, st_q, valid_q, e.c, e.st, e.v);
    end
    @(negedge clk);
    flush = 1'b1; rd1 = 32'd10;
    sb_q.push_back('{c: 32'd5, st: 32'd3, v: 1'b0});
    @(posedge clk); #1;
    e = sb_q.pop_front();
    checks++;
    if (c_q !== e.c || st_q !== e.st || valid_q !== e.v) begin
      errors++; $display("FAIL flush_hold: c_q=%h st_q=%h valid_q=%b required %h %h %b",
                         c_q, st_q, valid_q, e.c, e.st, e.v);
    end
    @(negedge clk);
    flush = 1'b0; rst = 1'b0; rd1 = 32'd2; #1;
    checks++;
    if (alu_c !== 32'd5) begin
      errors++; $display("FAIL rst_comb: alu_c=%h required %h", alu_c, 32'd5);
    end
    sb_q.push_back('{c: 32'd0, st: 32'd0, v: 1'b0});
    @(posedge clk); #1;
    e = sb_q.pop_front();
    checks++;
    if (c_q !== e.c || st_q !== e.st || valid_q !== e.v) begin
      errors++; $display("FAIL reg_rst: c_q=%h st_q=%h valid_q=%b required %h %h %b",
                         c_q, st_q, valid_q, e.c, e.st, e.v);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc, pst, fa, fb, b, c;
    pc = 32'd0; pst = 32'd0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      rst = 1'b1;
      flush = ($urandom_range(0, 4) == 0);
      in_valid = $urandom_range(0, 1);
      rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3));
      rd1 = $urandom; rd2 = $urandom; ext_b = $urandom;
      if ($urandom_range(0, 3) == 0) rd1 = rd2;
      alu_src = $urandom_range(0, 1);
      aluop = 4'($urandom_range(0, 15));
      sa = 5'($urandom_range(0, 31));
      use_mem_back = $urandom_range(0, 1); use_wb_back = $urandom_range(0, 1);
      mem_we = $urandom_range(0, 1); wb_we = $urandom_range(0, 1);
      mem_rw = 5'($urandom_range(0, 3)); wb_rw = 5'($urandom_range(0, 3));
      mem_data = $urandom; wb_data = $urandom;
      fa = m_fwd(rs, rd1);
      fb = m_fwd(rt, rd2);
      b = alu_src ? ext_b : fb;
      c = m_alu(aluop, fa, b, sa);
      #1;
      checks++;
      if (f_rd1 !== fa || f_rd2 !== fb || alu_c !== c || sum !== fa + b ||
          zero !== (c == 32'd0)) begin
        errors++;
        $display("FAIL b2b_comb[%0d] op=%0d: f_rd1=%h f_rd2=%h alu_c=%h sum=%h zero=%b required %h %h %h %h %b",
                 i, aluop, f_rd1, f_rd2, alu_c, sum, zero, fa, fb, c, fa + b, (c == 32'd0));
      end
      if (flush) begin
        sb_q.push_back('{c: pc, st: pst, v: 1'b0});
      end else begin
        sb_q.push_back('{c: c, st: fb, v: in_valid});
        pc = c; pst = fb;
      end
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++;
      if (c_q !== e.c || st_q !== e.st || valid_q !== e.v) begin
        errors++;
        $display("FAIL b2b_reg[%0d]: c_q=%h st_q=%h valid_q=%b required %h %h %b",
                 i, c_q, st_q, valid_q, e.c, e.st, e.v);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    set_defaults();
    test_reset();
    test_forward();
    test_r0();
    test_arith();
    test_shift();
    test_register_flush();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_alu_forward.md
# ex_alu_forward

Execute-stage datapath slice of the pipelined MIPS-style CPU. Resolves operand forwarding from the MEM and WB stages, selects the B operand, and computes the 32-bit ALU result, address sum and zero flag. It registers the result and forwarded store data into the EX/MEM boundary, with a valid bit that honours flush.

## Interface
Parameters:
- none; datapath width fixed at 32, register index width fixed at 5.

Ports:
- `clk`  in  1  pipeline clock; all state on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `flush`  in  1  EX flush; squashes the registered valid bit.
- `in_valid`  in  1  current EX instruction is live.
- `rs`, `rt`  in  5 each  source register indices (instr[25:21], instr[20:16]).
- `rd1`, `rd2`  in  32 each  register-file read data from ID/EX.
- `ext_b`  in  32  extended immediate.
- `alu_src`  in  1  1: B = `ext_b`; 0: B = forwarded rt value.
- `aluop`  in  4  ALU function code.
- `sa`  in  5  shift amount (instr[10:6]).
- `use_mem_back`, `use_wb_back`  in  1 each  enable forwarding from each source.
- `mem_we`, `mem_rw`, `mem_data`  in  1/5/32  MEM-stage writeback: write enable, destination, value.
- `wb_we`, `wb_rw`, `wb_data`  in  1/5/32  WB-stage writeback: write enable, destination, value.
- `f_rd1`, `f_rd2`  out  32 each  forwarded operands (combinational).
- `alu_c`  out  32  ALU result (combinational).
- `sum`  out  32  A+B, always computed (memory address).
- `zero`  out  1  `alu_c == 0`.
- `c_q`, `st_q`  out  32 each  registered `alu_c` and `f_rd2`.
- `valid_q`  out  1  registered valid.

## Operation
Forwarding is applied independently to rs→`f_rd1` and rt→`f_rd2`. For a source index `r`:
- If `use_mem_back && mem_we && mem_rw==r && r!=0`, the value is `mem_data`.
- Else if `use_wb_back && wb_we && wb_rw==r && r!=0`, the value is `wb_data`.
- Else the value is `rd1`/`rd2`.
- MEM has priority over WB when both match.
- Register 0 is never forwarded.

Operands: A = `f_rd1`; B = `alu_src ? ext_b : f_rd2`. `sum` = A+B mod 2^32 for every `aluop`.

ALU functions (`aluop`). No overflow trap; add and subtract wrap.
- 0 ADD: A+B
- 1 SUB: A−B
- 2 AND
- 3 OR
- 4 XOR
- 5 NOR
- 6 SLT: signed A<B → 32'h1, else 0
- 7 SLTU: unsigned A<B → 1, else 0
- 8 SLL: B<<sa
- 9 SRL: B>>sa, logical
- 10 SRA: B>>>sa, arithmetic
- 11 SLLV: B<<A[4:0]
- 12 SRLV: B>>A[4:0]
- 13 SRAV: B>>>A[4:0]
- 14 LUI: {B[15:0],16'h0}
- 15 PASSB: B

## Timing
- `f_rd1`, `f_rd2`, `alu_c`, `sum`, `zero` are purely combinational, same cycle as inputs.
- Registered outputs have 1-cycle latency.
- On rising edge with `rst==0`: `c_q`, `st_q`, `valid_q` ← 0. Reset dominates `flush`.
- Else if `flush`: `valid_q` ← 0; `c_q` and `st_q` hold their values.
- Else: `c_q` ← `alu_c`, `st_q` ← `f_rd2`, `valid_q` ← `in_valid`.
- Reset is sampled only on `clk`; asserting it mid-operation does not affect combinational outputs.

## Test plan
- Forward priority: rs=5, rd1=1, mem(we=1,rw=5,data=AA), wb(we=1,rw=5,data=BB) → `f_rd1`=AA. Drop `mem_we` → BB. Set `use_wb_back=0` → 1.
- r0 guard: rt=0, mem(we=1,rw=0,data=FFFF_FFFF), rd2=0 → `f_rd2`=0.
- Arithmetic: A=7FFF_FFFF, B=1, ADD → 8000_0000 with no trap. SUB with A=B=3 → 0, `zero`=1. SLT A=FFFF_FFFF, B=1 → 1. SLTU with the same operands → 0.
- Shifts and immediates: B=8000_0000, sa=4: SRL → 0800_0000, SRA → F800_0000. SLLV with A=33 → B<<1. LUI with `ext_b`=1234, `alu_src`=1 → 1234_0000.
- Register and flush: ADD 2+3 with `in_valid`=1 → next cycle `c_q`=5, `valid_q`=1. Assert `flush` → `valid_q`=0 with `c_q` still 5. Then `rst`=0 → all registered outputs 0.
